// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with scan-code FIFO for the memory-mapped peripheral bus.
// Pins are synchronised and sampled on a divided strobe. The keyboard clock is deglitched
// before its falling edges drive the frame FSM. Good bytes are queued for the CPU to pop.
module ps2_rx_fifo #(
    parameter int CLK_DIV       = 250,
    parameter int FILTER_LEN    = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sel,
    input  logic                          rd_en,
    input  logic                          clr_err,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [8:0]                    data_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       FLT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_STOP = 2'd2
    } state_t;

    // Synchroniser, divider and filter state
    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             stb;
    logic [3:0]       flt_cnt_q, flt_cnt_d;
    logic             filt_q, filt_d;
    logic             fall;

    // Frame FSM state
    state_t           state_q;
    logic [3:0]       bitcnt_q;
    logic [7:0]       sr_q;
    logic             par_q;
    logic [TO_W-1:0]  tcnt_q;
    logic             push_q;
    logic [7:0]       push_byte_q;
    logic             parity_err_q, frame_err_q;

    // FIFO state
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       data_out_q, data_out_d;
    logic             overflow_q;
    logic             do_pop, do_push, full, ovf_set;

    // Two-flop synchronisers; idle level of both PS/2 lines is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign stb = (div_q == DIV_LAST);

    // Strobe divider and ps2_clk deglitch filter next-state
    always_comb begin
        div_d     = stb ? '0 : div_q + DIV_W'(1);
        flt_cnt_d = flt_cnt_q;
        filt_d    = filt_q;
        if (stb) begin
            if (clk_s2_q != filt_q) begin
                if (flt_cnt_q == FLT_LAST) begin
                    filt_d    = ~filt_q;
                    flt_cnt_d = '0;
                end else begin
                    flt_cnt_d = flt_cnt_q + 4'd1;
                end
            end else begin
                flt_cnt_d = '0;
            end
        end
    end

    // A falling edge is the strobe on which the filtered clock toggles 1->0
    assign fall = stb && filt_q && !clk_s2_q && (flt_cnt_q == FLT_LAST);

    // Divider and filter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            flt_cnt_q <= '0;
            filt_q    <= 1'b1;
        end else begin
            div_q     <= div_d;
            flt_cnt_q <= flt_cnt_d;
            filt_q    <= filt_d;
        end
    end

    // Frame FSM: shifts bits on falling edges, checks the frame, raises push and error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            bitcnt_q     <= '0;
            sr_q         <= '0;
            par_q        <= 1'b0;
            tcnt_q       <= '0;
            push_q       <= 1'b0;
            push_byte_q  <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // Clear first so that a flag set later in this block wins
            if (sel && clr_err) begin
                parity_err_q <= 1'b0;
                frame_err_q  <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    tcnt_q <= '0;
                    if (fall && !dat_s2_q) begin
                        state_q  <= S_RECV;
                        bitcnt_q <= 4'd1;
                    end
                end
                default: begin
                    if (fall) begin
                        tcnt_q <= '0;
                        if (state_q == S_RECV) begin
                            if (bitcnt_q == 4'd9) begin
                                par_q    <= dat_s2_q;
                                bitcnt_q <= 4'd10;
                                state_q  <= S_STOP;
                            end else begin
                                sr_q     <= {dat_s2_q, sr_q[7:1]};
                                bitcnt_q <= bitcnt_q + 4'd1;
                            end
                        end else begin
                            state_q  <= S_IDLE;
                            bitcnt_q <= '0;
                            if (!(^{sr_q, par_q})) begin
                                parity_err_q <= 1'b1;
                            end
                            if (!dat_s2_q) begin
                                frame_err_q <= 1'b1;
                            end
                            if ((^{sr_q, par_q}) && dat_s2_q) begin
                                push_q      <= 1'b1;
                                push_byte_q <= sr_q;
                            end
                        end
                    end else if (stb) begin
                        if (tcnt_q == TO_LAST) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                            bitcnt_q    <= '0;
                            sr_q        <= '0;
                            tcnt_q      <= '0;
                        end else begin
                            tcnt_q <= tcnt_q + TO_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // FIFO control and registered head; the head bypasses a byte written this cycle
    always_comb begin
        full    = (cnt_q == CNT_FULL);
        do_pop  = sel && rd_en && (cnt_q != '0);
        do_push = push_q && (!full || do_pop);
        ovf_set = push_q && full && !do_pop;
        wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + PTR_W'(1) : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_d == '0) begin
            data_out_d = '0;
        end else if (do_push && (rd_d == wr_q)) begin
            data_out_d = {1'b1, push_byte_q};
        end else begin
            data_out_d = {1'b1, mem[rd_d]};
        end
    end

    // FIFO storage; contents are only meaningful under the pointers, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= push_byte_q;
        end
    end

    // FIFO pointers, occupancy, head register and overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (sel && clr_err) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_q;
    assign fifo_count = cnt_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames are bit-banged on the PS/2 pins with transitions
// aligned to the strobe phase so the push cycle is known exactly.
module tb_ps2_rx_fifo;

    localparam int CLK_DIV       = 4;
    localparam int FILTER_LEN    = 4;
    localparam int FIFO_DEPTH    = 8;
    localparam int TIMEOUT_TICKS = 40;
    localparam int HALF          = 40;   // clk cycles per PS/2 half period

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] data_out;
    logic [3:0] fifo_count;
    logic       parity_err, frame_err, overflow;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    ps2_rx_fifo #(
        .CLK_DIV(CLK_DIV), .FILTER_LEN(FILTER_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .rd_en(rd_en), .clr_err(clr_err),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .data_out(data_out),
        .fifo_count(fifo_count), .parity_err(parity_err), .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Mirrors the divider phase: strobe cycles follow posedges with cyc % CLK_DIV == CLK_DIV-1
    always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

    task automatic align();
        @(negedge clk);
        while (cyc % CLK_DIV != 0) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        align();
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // mode 0: plain, mode 1: pop in the push cycle, mode 2: check 2-clk head latency
    task automatic send_frame(input logic [7:0] d, input logic flip, input logic stopb,
                              input int mode);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d) ^ flip);
        align();
        ps2_data = stopb;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        // fall detected on strobe after posedge k+15, push cycle after posedge k+16
        repeat (16) @(negedge clk);
        if (mode == 1) begin
            sel = 1'b1;
            rd_en = 1'b1;
        end
        if (mode == 2) begin
            vectors++;
            if (data_out[8] !== 1'b0) begin
                miscompares++;
                $display("FAIL latency_early: data_out[8]=%b want 0", data_out[8]);
            end
        end
        @(negedge clk);
        sel = 1'b0;
        rd_en = 1'b0;
        if (mode == 2) begin
            vectors++;
            if (data_out !== {1'b1, d}) begin
                miscompares++;
                $display("FAIL latency_2clk: data_out=%h want %h", data_out, {1'b1, d});
            end
        end
        repeat (HALF - 17) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
    endtask

    task automatic pop();
        @(negedge clk);
        sel = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge clk);
        sel = 1'b1;
        clr_err = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (data_out !== 9'h000) begin miscompares++; $display("FAIL rst_data: got %h want 000", data_out); end
        vectors++;
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        vectors++;
        if ({parity_err, frame_err, overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_flags: got %b want 000", {parity_err, frame_err, overflow});
        end
        rst = 1'b1;
    endtask

    task automatic test_good_frame();
        send_frame(8'h1C, 1'b0, 1'b1, 2);
        vectors++;
        if (data_out !== 9'h11C) begin miscompares++; $display("FAIL good_data: got %h want 11c", data_out); end
        vectors++;
        if (fifo_count !== 4'd1) begin miscompares++; $display("FAIL good_count: got %0d want 1", fifo_count); end
        vectors++;
        if ({parity_err, frame_err, overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL good_flags: got %b want 000", {parity_err, frame_err, overflow});
        end
        pop();
        vectors++;
        if (data_out !== 9'h000) begin miscompares++; $display("FAIL pop_data: got %h want 000", data_out); end
        vectors++;
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL pop_count: got %0d want 0", fifo_count); end
        pop();
        vectors++;
        if ({fifo_count, overflow} !== 5'b0) begin
            miscompares++;
            $display("FAIL pop_empty: count=%0d ovf=%b want 0 0", fifo_count, overflow);
        end
    endtask

    task automatic test_errors();
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        vectors++;
        if ({parity_err, frame_err} !== 2'b10) begin
            miscompares++;
            $display("FAIL parity_flag: par/frm=%b want 10", {parity_err, frame_err});
        end
        vectors++;
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL parity_count: got %0d want 0", fifo_count); end
        clear_errors();
        vectors++;
        if (parity_err !== 1'b0) begin miscompares++; $display("FAIL parity_clr: got %b want 0", parity_err); end
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        vectors++;
        if ({parity_err, frame_err, fifo_count} !== {2'b01, 4'd0}) begin
            miscompares++;
            $display("FAIL stop_bad: par/frm=%b count=%0d want 01 0", {parity_err, frame_err}, fifo_count);
        end
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        vectors++;
        if (frame_err !== 1'b1) begin miscompares++; $display("FAIL clr_nosel: got %b want 1", frame_err); end
        clear_errors();
        vectors++;
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL frame_clr: got %b want 0", frame_err); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
        vectors++;
        if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            vectors++;
            if (data_out !== {1'b1, 8'(i)}) begin
                miscompares++;
                $display("FAIL ovf_order%0d: got %h want %h", i, data_out, {1'b1, 8'(i)});
            end
            pop();
        end
        vectors++;
        if ({data_out, fifo_count} !== 13'h0) begin
            miscompares++;
            $display("FAIL ovf_drained: data=%h count=%0d want 000 0", data_out, fifo_count);
        end
        clear_errors();
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    endtask

    task automatic test_timeout();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat ((TIMEOUT_TICKS + 20) * CLK_DIV) @(negedge clk);
        vectors++;
        if ({parity_err, frame_err, fifo_count} !== {2'b01, 4'd0}) begin
            miscompares++;
            $display("FAIL timeout: par/frm=%b count=%0d want 01 0", {parity_err, frame_err}, fifo_count);
        end
        clear_errors();
        send_frame(8'hF0, 1'b0, 1'b1, 0);
        vectors++;
        if (data_out !== 9'h1F0) begin miscompares++; $display("FAIL after_timeout: got %h want 1f0", data_out); end
        vectors++;
        if ({parity_err, frame_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL after_timeout_flags: got %b want 00", {parity_err, frame_err});
        end
        pop();
    endtask

    task automatic test_glitch();
        align();
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (2 * CLK_DIV) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        send_bit(1'b1);   // spurious start with data high
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        vectors++;
        if ({data_out, fifo_count} !== {9'h15A, 4'd1}) begin
            miscompares++;
            $display("FAIL glitch: data=%h count=%0d want 15a 1", data_out, fifo_count);
        end
        vectors++;
        if ({parity_err, frame_err} !== 2'b00) begin
            miscompares++;
            $display("FAIL glitch_flags: got %b want 00", {parity_err, frame_err});
        end
        pop();
    endtask

    task automatic test_full_pushpop();
        for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 0);
        vectors++;
        if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
            miscompares++;
            $display("FAIL full_pre: count=%0d ovf=%b want 8 0", fifo_count, overflow);
        end
        send_frame(8'h18, 1'b0, 1'b1, 1);
        vectors++;
        if ({fifo_count, overflow} !== {4'd8, 1'b0}) begin
            miscompares++;
            $display("FAIL full_pushpop: count=%0d ovf=%b want 8 0", fifo_count, overflow);
        end
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            vectors++;
            if (data_out !== {1'b1, 8'h10 + 8'(i)}) begin
                miscompares++;
                $display("FAIL full_order%0d: got %h want %h", i, data_out, {1'b1, 8'h10 + 8'(i)});
            end
            pop();
        end
        vectors++;
        if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL full_drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_midframe();
        send_frame(8'h33, 1'b0, 1'b1, 0);
        send_frame(8'h44, 1'b1, 1'b1, 0);
        vectors++;
        if ({data_out, parity_err} !== {9'h133, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_pre: data=%h par=%b want 133 1", data_out, parity_err);
        end
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if ({data_out, fifo_count, parity_err, frame_err, overflow} !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_rst: data=%h count=%0d flags=%b want all 0", data_out, fifo_count,
                     {parity_err, frame_err, overflow});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send_frame(8'h7E, 1'b0, 1'b1, 0);
        vectors++;
        if ({data_out, fifo_count} !== {9'h17E, 4'd1}) begin
            miscompares++;
            $display("FAIL mid_fresh: data=%h count=%0d want 17e 1", data_out, fifo_count);
        end
        vectors++;
        if ({parity_err, frame_err, overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_fresh_flags: got %b want 000", {parity_err, frame_err, overflow});
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_errors();
        test_overflow();
        test_timeout();
        test_glitch();
        test_full_pushpop();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
